full_adder_unit: RTL and testbench

- One-bit full adder (generalisable to a WIDTH-bit ripple adder). Adds operands x, y and carry-in z; produces sum on OUT_1 and carry-out on OUT_2.
- Sits as the top-level wrapper of the adder design, directly instantiated by the system bench.
- Outputs are registered on the clock by default. An optional combinational mode exists for the legacy behaviour.

---
 rtl/adder_pkg.sv | 12 +
 rtl/full_adder_cell.sv | 17 +
 rtl/full_adder_unit.sv | 61 ++++++
 tb/tb_full_adder_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the ripple-carry adder: default width and the {carry, sum} result type.
// No logic; consumed by the RTL and by the bench reference model.
package adder_pkg;

  localparam int DEF_WIDTH = 1;

  typedef struct packed {
    logic                 carry;
    logic [DEF_WIDTH-1:0] sum;
  } result_t;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder cell, purely combinational (zero latency, no flow control).
// Chained by full_adder_unit to form a WIDTH-bit ripple adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/full_adder_unit.sv
// WIDTH-bit ripple adder {OUT_2, OUT_1} = x + y + z; 1-cycle registered latency or combinational.
// No handshake: a new result every cycle, async active-high reset clears the output stage.
module full_adder_unit
  import adder_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter bit REGISTERED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             z,
  output logic [WIDTH-1:0] OUT_1,
  output logic             OUT_2
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;

  assign carry[0] = z;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder_cell u_cell (
      .a    (x[i]),
      .b    (y[i]),
      .cin  (carry[i]),
      .s    (sum_d[i]),
      .cout (carry[i+1])
    );
  end

  assign cout_d = carry[WIDTH];

  if (REGISTERED) begin : g_reg
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    // No enable: every edge captures, reset drops any in-flight result.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q  <= '0;
        cout_q <= 1'b0;
      end else begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end

    assign OUT_1 = sum_q;
    assign OUT_2 = cout_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign OUT_1 = sum_d;
    assign OUT_2 = cout_d;
  end

endmodule

// File: tb/tb_full_adder_unit.sv
// Bench for full_adder_unit: registered and combinational 1-bit instances plus a registered 4-bit one,
// with expected results queued at drive time and popped when the registered output appears.
module tb_full_adder_unit;
  import adder_pkg::*;

  logic       clk;
  logic       rst;
  logic       rst_c;
  logic       x1, y1, z1;
  logic       o1_s, o1_c;
  logic       xc, yc, zc;
  logic       oc_s, oc_c;
  logic [3:0] x4, y4;
  logic       z4;
  logic [3:0] o4_s;
  logic       o4_c;

  int n_checks = 0;
  int n_errors = 0;

  result_t    sb1[$];
  logic [4:0] sb4[$];

  full_adder_unit #(.WIDTH(1), .REGISTERED(1'b1)) dut_reg1 (
    .clk(clk), .rst(rst), .x(x1), .y(y1), .z(z1), .OUT_1(o1_s), .OUT_2(o1_c)
  );

  full_adder_unit #(.WIDTH(1), .REGISTERED(1'b0)) dut_comb1 (
    .clk(clk), .rst(rst_c), .x(xc), .y(yc), .z(zc), .OUT_1(oc_s), .OUT_2(oc_c)
  );

  full_adder_unit #(.WIDTH(4), .REGISTERED(1'b1)) dut_reg4 (
    .clk(clk), .rst(rst), .x(x4), .y(y4), .z(z4), .OUT_1(o4_s), .OUT_2(o4_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic result_t ref1(input logic a, input logic b, input logic c);
    logic [1:0] t;
    t = {1'b0, a} + {1'b0, b} + {1'b0, c};
    return result_t'(t);
  endfunction

  function automatic logic [4:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {4'b0, c};
  endfunction

  task automatic drive1(input logic [2:0] v);
    {x1, y1, z1} = v;
    sb1.push_back(ref1(v[2], v[1], v[0]));
  endtask

  task automatic pop1(input string tag);
    result_t e;
    if (sb1.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb1.size()), 32'd1);
    end else begin
      e = sb1.pop_front();
      check(tag, {30'b0, o1_c, o1_s}, {30'b0, e});
    end
  endtask

  task automatic pop4(input string tag);
    logic [4:0] e;
    if (sb4.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb4.size()), 32'd1);
    end else begin
      e = sb4.pop_front();
      check(tag, {27'b0, o4_c, o4_s}, {27'b0, e});
    end
  endtask

  initial begin
    logic [1:0] prev;
    logic [2:0] lat_vec [3];
    logic [3:0] wx [3];
    logic [3:0] wy [3];
    logic       wz [3];
    logic [4:0] wexp [3];

    rst = 1'b1; rst_c = 1'b1;
    x1 = 1'b0; y1 = 1'b0; z1 = 1'b0;
    xc = 1'b0; yc = 1'b0; zc = 1'b0;
    x4 = 4'h0; y4 = 4'h0; z4 = 1'b0;

    // Reset state, no clock edge needed.
    #2;
    x1 = 1'b1; y1 = 1'b1; z1 = 1'b1;
    #1;
    check("reset_r1", {30'b0, o1_c, o1_s}, 32'd0);
    check("reset_r4", {27'b0, o4_c, o4_s}, 32'd0);
    x1 = 1'b0; y1 = 1'b0; z1 = 1'b0;
    @(negedge clk) rst = 1'b0;

    // Exhaustive truth table, each vector held 50 ns.
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      drive1(3'(v));
      @(posedge clk); #1;
      pop1($sformatf("tt_%0d%0d%0d", v[2], v[1], v[0]));
      repeat (4) @(negedge clk);
    end

    // Async reset mid-operation.
    @(negedge clk);
    drive1(3'b111);
    @(posedge clk); #1;
    pop1("rst_pre_11");
    #2 rst = 1'b1;
    #1 check("rst_async", {30'b0, o1_c, o1_s}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("rst_hold_%0d", i), {30'b0, o1_c, o1_s}, 32'd0);
    end
    @(negedge clk) rst = 1'b0;
    #1 check("rst_rel_pre", {30'b0, o1_c, o1_s}, 32'd0);
    sb1.push_back(ref1(1'b1, 1'b1, 1'b1));
    @(posedge clk); #1;
    pop1("rst_rel_11");

    // Latency: outputs must lag inputs by exactly one edge.
    lat_vec[0] = 3'b001; lat_vec[1] = 3'b110; lat_vec[2] = 3'b000;
    prev = {o1_c, o1_s};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive1(lat_vec[i]);
      #1 check($sformatf("lat_hold_%0d", i), {30'b0, o1_c, o1_s}, {30'b0, prev});
      @(posedge clk); #1;
      prev = {o1_c, o1_s};
      pop1($sformatf("lat_%0d", i));
    end

    // Combinational instance with reset held high.
    for (int v = 0; v < 8; v++) begin
      {xc, yc, zc} = 3'(v);
      #1;
      check($sformatf("comb_%0d", v), {30'b0, oc_c, oc_s},
            {30'b0, ref1(xc, yc, zc)});
    end

    // Wide corner cases with hand-computed results.
    wx[0] = 4'hF; wy[0] = 4'h1; wz[0] = 1'b0; wexp[0] = 5'b1_0000;
    wx[1] = 4'h7; wy[1] = 4'h8; wz[1] = 1'b1; wexp[1] = 5'b1_0000;
    wx[2] = 4'h3; wy[2] = 4'h4; wz[2] = 1'b0; wexp[2] = 5'b0_0111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      x4 = wx[i]; y4 = wy[i]; z4 = wz[i];
      sb4.push_back(wexp[i]);
      @(posedge clk); #1;
      pop4($sformatf("wide_%0d", i));
    end
    @(negedge clk);
    x4 = 4'hF; y4 = 4'hF; z4 = 1'b1;
    sb4.push_back(5'b1_1111);
    @(posedge clk); #1;
    pop4("wide_allones");

    // Random back-to-back regression, driver and monitor run independently.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          x4 = 4'($urandom_range(0, 15));
          y4 = 4'($urandom_range(0, 15));
          z4 = 1'($urandom_range(0, 1));
          sb4.push_back(ref4(x4, y4, z4));
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          @(posedge clk); #1;
          pop4("rand");
        end
      end
    join

    check("sb1_drain", 32'(sb1.size()), 32'd0);
    check("sb4_drain", 32'(sb4.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
